button_sensor: RTL and testbench
================================

Name: button_sensor

Overview:
- AHB-Lite read-side input peripheral for the cycle-computer SoC, the input counterpart to the write-only display peripheral.
- Synchronises and debounces the two push buttons (mode, trip) and the two reed sensors (fork, crank).
- Captures press/pulse events in sticky read-to-clear status bits and counts fork/crank events.
- Provides a free-running tick timer so software can compute speed and cadence.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles at the new level required before the debounced level changes (range 1..255).
- TICK_DIV, 32, HCLK cycles per timer tick (range 2..65535).

Ports:
- HCLK  input  1  system clock.
- HRESETn  input  1  asynchronous active-low reset.
- HADDR  input  32  address; only HADDR[4:2] decoded.
- HWDATA  input  32  write data (ignored, see Behaviour).
- HWRITE  input  1  transfer direction.
- HREADY  input  1  bus ready.
- HSEL  input  1  slave select.
- HSIZE  input  3  ignored; all accesses treated as word.
- HTRANS  input  2  transfer type.
- HRDATA  output  32  read data.
- HREADYOUT  output  1  constant 1, no wait states.
- nMode  input  1  mode button, active low, asynchronous.
- nTrip  input  1  trip button, active low, asynchronous.
- nFork  input  1  fork reed sensor, active low, asynchronous.
- nCrank  input  1  crank reed sensor, active low, asynchronous.
- IRQ  output  1  OR of STATUS[3:0].

Behaviour:
- Clock and reset: one clock, HCLK. Reset is asynchronous and active-low on HRESETn.
- Reset values:
  - All synchronisers and debounced levels = 1 (released).
  - STATUS = 0, FORK_COUNT = 0, CRANK_COUNT = 0, TIMER = 0, prescaler = 0.
  - IRQ = 0, HRDATA = 0, HREADYOUT = 1.
- Bus capture: the address phase is accepted when HSEL && HREADY && HTRANS[1]. On the following edge the peripheral registers HWRITE, HADDR[4:2] and a valid flag. Otherwise the valid flag is registered as 0.
- Read data: HRDATA is combinational from the registered address during a valid read data phase, and 0 otherwise.
- Register map (word offset):
  - 0 STATUS: [0] mode pressed, [1] trip pressed, [2] fork event, [3] crank event, upper bits 0.
  - 1 FORK_COUNT: 16 bits, zero-extended.
  - 2 CRANK_COUNT: 16 bits, zero-extended.
  - 3 TIMER: 16 bits, zero-extended.
  - 4..7: read 0, writes ignored.
- STATUS reads: a valid read data phase at offset 0 clears STATUS at the end of that cycle.
- Writes, applied at the end of the data phase:
  - Any write to offset 1, 2 or 3 clears that register; HWDATA value is ignored.
  - A write to offset 3 also clears the prescaler.
  - Writes to offset 0 are ignored.
- Synchroniser: two flops per input. sync2 is the second flop's output.
- Debounce, per input:
  - An 8-bit counter increments each cycle sync2 != db, and resets to 0 on any cycle sync2 == db.
  - When sync2 != db and counter == DEBOUNCE_CYCLES-1, db <= sync2 and the counter resets.
  - A pulse shorter than DEBOUNCE_CYCLES synchronised cycles never changes db.
- Event: a db transition 1->0 sets the matching STATUS bit on the same edge. Fork/crank events also increment their counter on that edge.
- Latency: input low before edge k -> STATUS bit and count visible after edge k+1+DEBOUNCE_CYCLES.
- Counters: 16-bit counters wrap 0xFFFF -> 0x0000.
- Timer: the prescaler counts 0..TICK_DIV-1. TIMER increments on the edge the prescaler wraps, and TIMER wraps at 0xFFFF.
- Simultaneous events:
  - STATUS read-clear and a new event on the same bit in the same cycle: the bit ends 1. Other bits clear.
  - Counter clear-write and an event in the same cycle: the counter ends at 1.
  - TIMER clear and a tick in the same cycle: TIMER ends 0.
- Reset mid-operation: reset asserted at any time returns all state to reset values immediately. A held-low input produces an event DEBOUNCE_CYCLES+2 cycles after reset release.

Test Plan (DEBOUNCE_CYCLES = 4, TICK_DIV = 32):
1. nMode low from edge 0 and held -> STATUS reads 0x1 after edge 5; IRQ = 1. Read offset 0 returns 0x1, next read returns 0x0, and IRQ = 0.
2. nFork low for 3 cycles, then high -> no event: STATUS = 0, FORK_COUNT = 0. Ten clean 20-cycle fork pulses -> FORK_COUNT reads 10, STATUS reads 0x4.
3. Preload CRANK_COUNT to 0xFFFF via 65535 crank pulses (or a forced value), then one more pulse -> reads 0x0000.
4. Write to offset 1 on the same edge a fork event is registered -> FORK_COUNT reads 1. A STATUS read coinciding with a new trip event -> following read returns 0x2.
5. After reset, 320 cycles -> TIMER reads 10. Write offset 3 -> TIMER reads 0, and the next tick arrives exactly 32 cycles after the write.
6. Reads of offsets 4..7 return 0. Every cycle HREADYOUT = 1. HTRANS = IDLE with HSEL = 1 -> no read-clear and no write effect. HRESETn pulsed low mid-debounce -> all registers 0, IRQ = 0.

Source files
------------

// File: rtl/button_sensor.sv
// AHB-Lite input peripheral: synchronises and debounces two buttons and two reed sensors,
// latches sticky read-to-clear events, counts fork/crank pulses and runs a free tick timer.
module button_sensor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TICK_DIV        = 32
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    input  logic        nMode,
    input  logic        nTrip,
    input  logic        nFork,
    input  logic        nCrank,
    output logic        IRQ
);
    localparam int unsigned NUM_IN = 4;
    localparam int unsigned DB_W   = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OFS_W  = 3;
    localparam int unsigned IN_FORK  = 2;
    localparam int unsigned IN_CRANK = 3;

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [OFS_W-1:0] OFS_STATUS = OFS_W'(0);
    localparam logic [OFS_W-1:0] OFS_FORK   = OFS_W'(1);
    localparam logic [OFS_W-1:0] OFS_CRANK  = OFS_W'(2);
    localparam logic [OFS_W-1:0] OFS_TIMER  = OFS_W'(3);

    typedef struct packed {
        logic             valid;
        logic             write;
        logic [OFS_W-1:0] addr;
    } bus_cap_t;

    logic [NUM_IN-1:0]            raw_c;
    logic [NUM_IN-1:0]            sync1_q, sync2_q;
    logic [NUM_IN-1:0]            db_q, db_d;
    logic [NUM_IN-1:0][DB_W-1:0]  dcnt_q, dcnt_d;
    logic [NUM_IN-1:0]            event_c;
    bus_cap_t                     bus_q, bus_d;
    logic                         rd_c, wr_c, tick_c;
    logic [NUM_IN-1:0]            status_q, status_d;
    logic [CNT_W-1:0]             fork_cnt_q, fork_cnt_d;
    logic [CNT_W-1:0]             crank_cnt_q, crank_cnt_d;
    logic [CNT_W-1:0]             timer_q, timer_d;
    logic [CNT_W-1:0]             presc_q, presc_d;
    logic [DATA_W-1:0]            rdata_c;
    logic                         unused_c;

    assign raw_c = {nCrank, nFork, nTrip, nMode};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            db_q        <= '1;
            dcnt_q      <= '0;
            bus_q       <= '0;
            status_q    <= '0;
            fork_cnt_q  <= '0;
            crank_cnt_q <= '0;
            timer_q     <= '0;
            presc_q     <= '0;
        end else begin
            sync1_q     <= raw_c;
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            dcnt_q      <= dcnt_d;
            bus_q       <= bus_d;
            status_q    <= status_d;
            fork_cnt_q  <= fork_cnt_d;
            crank_cnt_q <= crank_cnt_d;
            timer_q     <= timer_d;
            presc_q     <= presc_d;
        end
    end

    // Debounce: count consecutive cycles the synchronised level disagrees with db
    always_comb begin
        db_d   = db_q;
        dcnt_d = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (dcnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign event_c = db_q & ~db_d;

    // Address-phase capture
    always_comb begin
        bus_d = '0;
        if (HSEL && HREADY && HTRANS[1]) begin
            bus_d.valid = 1'b1;
            bus_d.write = HWRITE;
            bus_d.addr  = HADDR[4:2];
        end
    end

    assign rd_c = bus_q.valid & ~bus_q.write;
    assign wr_c = bus_q.valid &  bus_q.write;

    // Clears are applied before events so a coincident event survives
    always_comb begin
        status_d    = status_q;
        fork_cnt_d  = fork_cnt_q;
        crank_cnt_d = crank_cnt_q;
        timer_d     = timer_q;
        tick_c      = (presc_q == PRESC_LAST);
        presc_d     = tick_c ? '0 : presc_q + CNT_W'(1);
        if (tick_c) begin
            timer_d = timer_q + CNT_W'(1);
        end
        if (rd_c && (bus_q.addr == OFS_STATUS)) begin
            status_d = '0;
        end
        if (wr_c) begin
            case (bus_q.addr)
                OFS_FORK:  fork_cnt_d  = '0;
                OFS_CRANK: crank_cnt_d = '0;
                OFS_TIMER: begin
                    timer_d = '0;
                    presc_d = '0;
                end
                default: ;
            endcase
        end
        status_d = status_d | event_c;
        if (event_c[IN_FORK]) begin
            fork_cnt_d = fork_cnt_d + CNT_W'(1);
        end
        if (event_c[IN_CRANK]) begin
            crank_cnt_d = crank_cnt_d + CNT_W'(1);
        end
    end

    always_comb begin
        rdata_c = '0;
        if (rd_c) begin
            case (bus_q.addr)
                OFS_STATUS: rdata_c = DATA_W'(status_q);
                OFS_FORK:   rdata_c = DATA_W'(fork_cnt_q);
                OFS_CRANK:  rdata_c = DATA_W'(crank_cnt_q);
                OFS_TIMER:  rdata_c = DATA_W'(timer_q);
                default:    rdata_c = '0;
            endcase
        end
    end

    assign HRDATA    = rdata_c;
    assign HREADYOUT = 1'b1;
    assign IRQ       = |status_q;

    assign unused_c = ^{HWDATA, HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0]};

endmodule

// File: tb/tb_button_sensor.sv
// Bench for button_sensor: directed scenarios plus random traffic, all reads checked
// through a scoreboard fed by a sample-window reference model.
module tb_button_sensor;
    localparam int unsigned DEB = 4;
    localparam int unsigned DIV = 32;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HREADY;
    logic        HSEL;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        nMode, nTrip, nFork, nCrank;
    logic        IRQ;

    int total = 0;
    int bad   = 0;

    button_sensor #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(DIV)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .nMode(nMode), .nTrip(nTrip), .nFork(nFork), .nCrank(nCrank), .IRQ(IRQ)
    );

    initial forever #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Raw level sampled at each edge; bit k = sample taken k edges ago.
    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] val;
    } exp_t;
    exp_t        exp_q[$];
    logic [15:0] samp [4];
    logic [3:0]  m_db, m_status, m_raw, m_ev;
    logic [15:0] m_fork, m_crank;
    int          m_cyc;
    logic        m_rd, m_wr;
    logic [2:0]  m_addr;
    logic        crank_preload = 1'b0;

    // The level flips once the DEB samples taken 2..DEB+1 edges ago all show the new level.
    function automatic bit settled(input logic [15:0] s, input logic v);
        for (int k = 2; k < int'(DEB) + 2; k++) begin
            if (s[k] !== v) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_reg(input logic [2:0] a);
        case (a)
            3'd0:    return {28'd0, m_status};
            3'd1:    return {16'd0, m_fork};
            3'd2:    return {16'd0, m_crank};
            3'd3:    return 32'((m_cyc / int'(DIV)) % 65536);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 4; i++) samp[i] = '1;
            m_db     = '1;
            m_status = '0;
            m_fork   = '0;
            m_crank  = '0;
            m_cyc    = 0;
            m_rd     = 1'b0;
            m_wr     = 1'b0;
            m_addr   = '0;
            exp_q.delete();
        end else begin
            m_raw = {nCrank, nFork, nTrip, nMode};
            m_ev  = '0;
            for (int i = 0; i < 4; i++) begin
                samp[i] = {samp[i][14:0], m_raw[i]};
                if (settled(samp[i], ~m_db[i])) begin
                    m_ev[i] = m_db[i];
                    m_db[i] = ~m_db[i];
                end
            end
            if (crank_preload) m_crank = 16'hFFFF;
            if (m_rd && m_addr == 3'd0) m_status = '0;
            m_status = m_status | m_ev;
            if (m_wr && m_addr == 3'd1) m_fork = '0;
            if (m_wr && m_addr == 3'd2) m_crank = '0;
            if (m_ev[2]) m_fork = m_fork + 16'd1;
            if (m_ev[3]) m_crank = m_crank + 16'd1;
            if (m_wr && m_addr == 3'd3) m_cyc = 0;
            else m_cyc = m_cyc + 1;
            m_rd   = HSEL && HREADY && HTRANS[1] && !HWRITE;
            m_wr   = HSEL && HREADY && HTRANS[1] && HWRITE;
            m_addr = HADDR[4:2];
            if (m_rd) exp_q.push_back('{addr: m_addr, val: m_reg(m_addr)});
        end
    end

    // ---------------- monitor ----------------
    always @(negedge HCLK) begin
        if (HRESETn) begin
            exp_t e;
            check("hreadyout", 32'(HREADYOUT), 32'd1);
            check("irq", 32'(IRQ), 32'(|m_status));
            if (m_rd) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("sb_rdata_ofs%0d", e.addr), HRDATA, e.val);
                end
            end else begin
                check("rdata_idle", HRDATA, 32'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = '0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            bus_idle();
            @(negedge HCLK);
        end
    endtask

    task automatic xfer(input logic sel, input logic [1:0] trans, input logic wr, input logic [2:0] ofs);
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HADDR  = {27'd0, ofs, 2'b00};
        HWDATA = $urandom;
        @(negedge HCLK);
        bus_idle();
    endtask

    task automatic rd_chk(input logic [2:0] ofs, input logic [31:0] want, input string name);
        xfer(1'b1, 2'b10, 1'b0, ofs);
        check(name, HRDATA, want);
    endtask

    initial begin
        int         hold [4];
        logic [3:0] lvl;
        HRESETn = 1'b0;
        {nCrank, nFork, nTrip, nMode} = 4'hF;
        HREADY = 1'b1;
        HSIZE  = 3'd2;
        HWDATA = '0;
        bus_idle();
        repeat (2) @(negedge HCLK);
        check("rst_irq", 32'(IRQ), 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        HRESETn = 1'b1;
        cyc(3);

        // Mode press: event lands DEB+1 edges after the first low sample
        nMode = 1'b0;
        cyc(5);
        check("t1_irq_early", 32'(IRQ), 32'd0);
        cyc(1);
        check("t1_irq_set", 32'(IRQ), 32'd1);
        rd_chk(3'd0, 32'h1, "t1_status");
        rd_chk(3'd0, 32'h0, "t1_status_clr");
        check("t1_irq_clr", 32'(IRQ), 32'd0);
        nMode = 1'b1;
        cyc(10);

        // Short glitch, then ten clean fork pulses
        nFork = 1'b0;
        cyc(3);
        nFork = 1'b1;
        cyc(10);
        rd_chk(3'd0, 32'h0, "t2_glitch_status");
        rd_chk(3'd1, 32'h0, "t2_glitch_count");
        repeat (10) begin
            nFork = 1'b0;
            cyc(10);
            nFork = 1'b1;
            cyc(10);
        end
        rd_chk(3'd1, 32'd10, "t2_fork_count");
        rd_chk(3'd0, 32'h4, "t2_status");

        // Crank counter wrap from a preloaded 0xFFFF
        crank_preload = 1'b1;
        force dut.crank_cnt_q = 16'hFFFF;
        #1;
        release dut.crank_cnt_q;
        cyc(1);
        crank_preload = 1'b0;
        rd_chk(3'd2, 32'h0000_FFFF, "t3_preload");
        nCrank = 1'b0;
        cyc(10);
        nCrank = 1'b1;
        cyc(10);
        rd_chk(3'd2, 32'h0, "t3_wrap");
        rd_chk(3'd0, 32'h8, "t3_status");

        // Fork-count clear on the event edge, then status read-clear on a trip event edge
        nFork = 1'b0;
        cyc(4);
        xfer(1'b1, 2'b10, 1'b1, 3'd1);
        rd_chk(3'd1, 32'd1, "t4_clr_vs_event");
        nFork = 1'b1;
        cyc(10);
        nTrip = 1'b0;
        cyc(4);
        rd_chk(3'd0, 32'h4, "t4_status_pre");
        rd_chk(3'd0, 32'h2, "t4_status_vs_event");
        nTrip = 1'b1;
        cyc(10);

        // Timer: tick every DIV cycles from reset, restart on write
        HRESETn = 1'b0;
        cyc(2);
        HRESETn = 1'b1;
        cyc(318);
        rd_chk(3'd3, 32'd9, "t5_timer_319");
        rd_chk(3'd3, 32'd10, "t5_timer_320");
        xfer(1'b1, 2'b10, 1'b1, 3'd3);
        rd_chk(3'd3, 32'd0, "t5_timer_clr");
        cyc(30);
        rd_chk(3'd3, 32'd0, "t5_pre_tick");
        rd_chk(3'd3, 32'd1, "t5_tick");

        // Unmapped offsets, ignored transfers
        for (int a = 4; a < 8; a++) begin
            xfer(1'b1, 2'b10, 1'b1, 3'(a));
            rd_chk(3'(a), 32'd0, "t6_hole");
        end
        nMode = 1'b0;
        nFork = 1'b0;
        cyc(8);
        {nMode, nFork} = 2'b11;
        cyc(8);
        xfer(1'b1, 2'b10, 1'b1, 3'd0);
        xfer(1'b1, 2'b00, 1'b0, 3'd0);
        xfer(1'b1, 2'b01, 1'b0, 3'd0);
        xfer(1'b1, 2'b00, 1'b1, 3'd1);
        HREADY = 1'b0;
        xfer(1'b1, 2'b10, 1'b0, 3'd0);
        HREADY = 1'b1;
        rd_chk(3'd1, 32'd1, "t6_idle_write");
        rd_chk(3'd0, 32'h5, "t6_status_kept");

        // Reset mid-debounce with trip held low across release
        nMode = 1'b0;
        cyc(8);
        nMode = 1'b1;
        nTrip = 1'b0;
        cyc(2);
        check("t6_irq_before_rst", 32'(IRQ), 32'd1);
        HRESETn = 1'b0;
        #1;
        check("t6_rst_irq", 32'(IRQ), 32'd0);
        check("t6_rst_hrdata", HRDATA, 32'd0);
        cyc(2);
        HRESETn = 1'b1;
        cyc(5);
        check("t6_held_early", 32'(IRQ), 32'd0);
        cyc(1);
        check("t6_held_event", 32'(IRQ), 32'd1);
        rd_chk(3'd0, 32'h2, "t6_rst_status");
        rd_chk(3'd1, 32'd0, "t6_rst_fork");
        rd_chk(3'd2, 32'd0, "t6_rst_crank");
        rd_chk(3'd3, 32'd0, "t6_rst_timer");
        nTrip = 1'b1;
        cyc(10);

        // Random traffic against the model
        for (int i = 0; i < 4; i++) hold[i] = 0;
        lvl = 4'hF;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    lvl[i]  = 1'($urandom_range(0, 1));
                    hold[i] = int'($urandom_range(1, 12));
                end
                hold[i]--;
            end
            {nCrank, nFork, nTrip, nMode} = lvl;
            HSEL   = 1'($urandom_range(0, 1));
            HTRANS = 2'($urandom_range(0, 3));
            HWRITE = ($urandom_range(0, 3) == 0);
            HREADY = ($urandom_range(0, 7) != 0);
            HADDR  = $urandom;
            HWDATA = $urandom;
            @(negedge HCLK);
        end
        HREADY = 1'b1;
        cyc(5);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
